// File: rtl/parking_slot_if.sv
// Entry-gate handshake between the slot allocator (master) and the gate controller (slave).
interface parking_slot_if;
  logic       entry_req;
  logic       grant_ack;
  logic       grant_valid;
  logic [1:0] grant_slot;

  modport master (output grant_valid, grant_slot, input entry_req, grant_ack);
  modport slave  (input grant_valid, grant_slot, output entry_req, grant_ack);
endinterface

// File: rtl/parking_slot_allocator.sv
// Debounces four slot sensors into an occupancy map and offers the lowest free slot
// to the entry gate, holding a reservation until the car parks or a timeout expires.
module parking_slot_allocator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            sensor,
  parking_slot_if.master        gate,
  output logic [3:0]            occupancy,
  output logic [2:0]            free_count,
  output logic                  full,
  output logic                  timeout_err
);

  localparam int unsigned NSLOT = 4;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, OFFER, PARK} state_t;

  state_t             state, state_d;
  logic [3:0]         sync1, sync2;
  logic [CNT_W-1:0]   db_cnt [NSLOT];
  logic [3:0]         reserved, reserved_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic               grant_valid_d;
  logic [1:0]         grant_slot_d;
  logic               timeout_err_d;
  logic [3:0]         free_map;
  logic [1:0]         lowest_free;
  logic [2:0]         free_cnt_d;

  // Synchronize raw sensors, then require DEBOUNCE_CYCLES consecutive disagreements to flip a bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      occupancy <= '0;
      for (int i = 0; i < NSLOT; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      for (int i = 0; i < NSLOT; i++) begin
        if (sync2[i] == occupancy[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i]    <= '0;
          occupancy[i] <= ~occupancy[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign free_map   = ~(occupancy | reserved);
  assign free_cnt_d = 3'(free_map[0]) + 3'(free_map[1]) + 3'(free_map[2]) + 3'(free_map[3]);

  always_comb begin
    lowest_free = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (free_map[i]) lowest_free = 2'(i);
    end
  end

  // Offer / reservation sequencing; acceptance wins over a same-edge withdrawal
  always_comb begin
    state_d       = state;
    grant_valid_d = gate.grant_valid;
    grant_slot_d  = gate.grant_slot;
    reserved_d    = reserved;
    timer_d       = timer;
    timeout_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (gate.entry_req && (free_map != '0)) begin
          grant_slot_d  = lowest_free;
          grant_valid_d = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (gate.grant_ack) begin
          reserved_d[gate.grant_slot] = 1'b1;
          grant_valid_d               = 1'b0;
          timer_d                     = '0;
          state_d                     = PARK;
        end else if (occupancy[gate.grant_slot]) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      PARK: begin
        timer_d = timer + TMR_W'(1);
        if (occupancy[gate.grant_slot]) begin
          reserved_d[gate.grant_slot] = 1'b0;
          state_d                     = IDLE;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          reserved_d[gate.grant_slot] = 1'b0;
          timeout_err_d               = 1'b1;
          state_d                     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      gate.grant_valid <= 1'b0;
      gate.grant_slot  <= '0;
      reserved         <= '0;
      timer            <= '0;
      timeout_err      <= 1'b0;
      free_count       <= 3'd4;
      full             <= 1'b0;
    end else begin
      state            <= state_d;
      gate.grant_valid <= grant_valid_d;
      gate.grant_slot  <= grant_slot_d;
      reserved         <= reserved_d;
      timer            <= timer_d;
      timeout_err      <= timeout_err_d;
      free_count       <= free_cnt_d;
      full             <= (free_cnt_d == 3'd0);
    end
  end

endmodule
